// File: rtl/uart_regs_pkg.sv
// Shared constants for the 16550-style host register file: register
// addresses, IIR codes and bit positions inside LCR, LSR and IER.
package uart_regs_pkg;

  // Host register addresses
  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_IER     = 3'd1;
  localparam logic [2:0] ADDR_IIR_FCR = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_MCR     = 3'd4;
  localparam logic [2:0] ADDR_LSR     = 3'd5;
  localparam logic [2:0] ADDR_MSR     = 3'd6;
  localparam logic [2:0] ADDR_SCR     = 3'd7;

  // Interrupt identification codes
  localparam logic [7:0] IIR_NONE = 8'h01;
  localparam logic [7:0] IIR_THRE = 8'h02;
  localparam logic [7:0] IIR_RDA  = 8'h04;
  localparam logic [7:0] IIR_RLS  = 8'h06;

  // LCR bit positions
  localparam int LCR_WLS0 = 0;
  localparam int LCR_WLS1 = 1;
  localparam int LCR_STB  = 2;
  localparam int LCR_PEN  = 3;
  localparam int LCR_EPS  = 4;
  localparam int LCR_DLAB = 7;

  // LSR bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_BI   = 4;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  localparam int LSR_ERR  = 7;

  // IER bit positions
  localparam int IER_RDA  = 0;
  localparam int IER_THRE = 1;
  localparam int IER_RLS  = 2;

  // Index of each line error inside the 3-bit sticky error vector
  localparam int ERR_OE = 0;
  localparam int ERR_PE = 1;
  localparam int ERR_FE = 2;

  // Word length encoded in LCR[1:0] is 5..8 data bits
  function automatic logic [3:0] lcr_data_bits(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

  // Assemble the line status register from live and sticky flags
  function automatic logic [7:0] build_lsr(input logic rx_rdy, input logic tx_rdy,
                                           input logic [2:0] sticky);
    logic [7:0] v;
    v           = 8'h00;
    v[LSR_DR]   = rx_rdy;
    v[LSR_OE]   = sticky[ERR_OE];
    v[LSR_PE]   = sticky[ERR_PE];
    v[LSR_FE]   = sticky[ERR_FE];
    v[LSR_BI]   = 1'b0;
    v[LSR_THRE] = tx_rdy;
    v[LSR_TEMT] = tx_rdy;
    v[LSR_ERR]  = sticky[ERR_PE] | sticky[ERR_FE];
    return v;
  endfunction

endpackage

// File: rtl/uart_regs_if.sv
// Host-side register bus: chip select, strobes, address and data.
interface uart_regs_if;
  logic       cs;
  logic       we;
  logic       re;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, we, re, addr, wdata, input rdata);
  modport slave  (input cs, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/uart_int_ctrl.sv
// Interrupt controller: sticky line-error bits, THRE pending flag,
// IIR priority encoding and the registered interrupt request.
module uart_int_ctrl
  import uart_regs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ier,
  input  logic       tx_ready,
  input  logic       rx_ready,
  input  logic [2:0] err_in,
  input  logic       lsr_rd,
  input  logic       iir_rd,
  input  logic       thr_wr,
  input  logic       ier_thre_set,
  output logic [2:0] sticky,
  output logic [7:0] iir,
  output logic       intr
);

  logic [2:0] sticky_reg;
  logic       tx_ready_d_reg;
  logic       pending_reg;
  logic       pending_next;
  logic       thre_set;
  logic       thre_clr;
  logic       intr_reg;

  // Sticky error bits: a concurrent error input beats the clearing LSR read
  for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sticky_reg[gi] <= 1'b0;
      else        sticky_reg[gi] <= (sticky_reg[gi] & ~lsr_rd) | err_in[gi];
    end
  end

  // THRE pending: set on tx_ready rising or IER[1] enabled while ready; set wins
  always_comb begin
    thre_set     = (tx_ready & ~tx_ready_d_reg) | (ier_thre_set & tx_ready);
    thre_clr     = thr_wr | (iir_rd & (iir == IIR_THRE));
    pending_next = thre_set | (pending_reg & ~thre_clr);
  end

  // Pending flag, tx_ready edge history and registered interrupt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready_d_reg <= 1'b0;
      pending_reg    <= 1'b0;
      intr_reg       <= 1'b0;
    end else begin
      tx_ready_d_reg <= tx_ready;
      pending_reg    <= pending_next;
      intr_reg       <= ~iir[0];
    end
  end

  // Priority encoder: line status, then received data, then THR empty
  always_comb begin
    iir = IIR_NONE;
    if (ier[IER_RLS] && (sticky_reg != 3'b000)) iir = IIR_RLS;
    else if (ier[IER_RDA] && rx_ready)          iir = IIR_RDA;
    else if (ier[IER_THRE] && pending_reg)      iir = IIR_THRE;
  end

  assign sticky = sticky_reg;
  assign intr   = intr_reg;

endmodule

// File: rtl/uart_regs.sv
// 16550-compatible host register file: address decode, register storage,
// registered read mux and the TX/RX/configuration handshakes to uart_top.
module uart_regs
  import uart_regs_pkg::*;
#(
  parameter int DL_WIDTH   = 16,
  parameter int PSD_WIDTH  = 4,
  parameter int DEFAULT_DL = 651
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_regs_if.slave           bus,
  output logic                 intr,
  output logic                 wr_en,
  output logic [7:0]           wr_data,
  input  logic                 tx_ready,
  output logic                 rd_en,
  input  logic [7:0]           rd_data,
  input  logic                 rx_ready,
  input  logic                 parity_err,
  input  logic                 framing_err,
  input  logic                 overrun_err,
  output logic [1:0]           stop_bits,
  output logic                 parity_en,
  output logic                 parity_even,
  output logic [3:0]           data_bits,
  output logic [DL_WIDTH-1:0]  divisor_latch,
  output logic [PSD_WIDTH-1:0] psd,
  output logic                 new_baud
);

  localparam int DLM_W = DL_WIDTH - 8;

  logic [2:0]           ier_reg;
  logic [7:0]           lcr_reg;
  logic [7:0]           mcr_reg;
  logic [7:0]           scr_reg;
  logic [DL_WIDTH-1:0]  dl_reg;
  logic [PSD_WIDTH-1:0] psd_reg;
  logic [7:0]           rdata_reg;
  logic                 boot_reg;
  logic                 new_baud_reg;

  logic       wr, rd, dlab;
  logic       thr_wr, rbr_rd, ier_wr, lcr_wr, mcr_wr, scr_wr;
  logic       dll_wr, dlm_wr, psd_wr, lsr_rd, iir_rd;
  logic       ier_thre_set;
  logic [2:0] sticky;
  logic [7:0] iir;
  logic [7:0] lsr;
  logic [7:0] rd_mux;

  // Address decode; DLAB remaps addresses 0, 1 and 5 onto the baud registers
  always_comb begin
    wr     = bus.cs & bus.we;
    rd     = bus.cs & bus.re;
    dlab   = lcr_reg[LCR_DLAB];
    thr_wr = wr & (bus.addr == ADDR_RBR_THR) & ~dlab;
    rbr_rd = rd & (bus.addr == ADDR_RBR_THR) & ~dlab;
    dll_wr = wr & (bus.addr == ADDR_RBR_THR) &  dlab;
    ier_wr = wr & (bus.addr == ADDR_IER)     & ~dlab;
    dlm_wr = wr & (bus.addr == ADDR_IER)     &  dlab;
    lcr_wr = wr & (bus.addr == ADDR_LCR);
    mcr_wr = wr & (bus.addr == ADDR_MCR);
    psd_wr = wr & (bus.addr == ADDR_LSR)     &  dlab;
    lsr_rd = rd & (bus.addr == ADDR_LSR)     & ~dlab;
    scr_wr = wr & (bus.addr == ADDR_SCR);
    iir_rd = rd & (bus.addr == ADDR_IIR_FCR);
    ier_thre_set = ier_wr & bus.wdata[IER_THRE] & ~ier_reg[IER_THRE];
  end

  // Handshakes to uart_top are combinational and suppressed during reset
  assign wr_en   = rst_n & thr_wr & tx_ready;
  assign rd_en   = rst_n & rbr_rd & rx_ready;
  assign wr_data = bus.wdata;

  // Host-writable storage and the baud-reload pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier_reg      <= 3'b000;
      lcr_reg      <= 8'h03;
      mcr_reg      <= 8'h00;
      scr_reg      <= 8'h00;
      dl_reg       <= DL_WIDTH'(DEFAULT_DL);
      psd_reg      <= '0;
      boot_reg     <= 1'b0;
      new_baud_reg <= 1'b0;
    end else begin
      if (ier_wr) ier_reg <= bus.wdata[2:0];
      if (lcr_wr) lcr_reg <= bus.wdata;
      if (mcr_wr) mcr_reg <= bus.wdata;
      if (scr_wr) scr_reg <= bus.wdata;
      if (dll_wr) dl_reg[7:0] <= bus.wdata;
      if (dlm_wr) dl_reg[DL_WIDTH-1:8] <= DLM_W'(bus.wdata);
      if (psd_wr) psd_reg <= PSD_WIDTH'(bus.wdata);
      boot_reg     <= 1'b1;
      new_baud_reg <= ~boot_reg | dll_wr | dlm_wr | psd_wr;
    end
  end

  // Read multiplexer feeding the registered read data
  always_comb begin
    rd_mux = 8'h00;
    case (bus.addr)
      ADDR_RBR_THR: rd_mux = dlab ? dl_reg[7:0] : (rx_ready ? rd_data : 8'h00);
      ADDR_IER:     rd_mux = dlab ? 8'(dl_reg[DL_WIDTH-1:8]) : {5'b00000, ier_reg};
      ADDR_IIR_FCR: rd_mux = iir;
      ADDR_LCR:     rd_mux = lcr_reg;
      ADDR_MCR:     rd_mux = mcr_reg;
      ADDR_LSR:     rd_mux = dlab ? 8'(psd_reg) : lsr;
      ADDR_MSR:     rd_mux = 8'h00;
      ADDR_SCR:     rd_mux = scr_reg;
      default:      rd_mux = 8'h00;
    endcase
  end

  // Read data is captured on the read edge and held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_reg <= 8'h00;
    else if (rd) rdata_reg <= rd_mux;
  end

  assign lsr = build_lsr(rx_ready, tx_ready, sticky);

  uart_int_ctrl u_int_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .ier          (ier_reg),
    .tx_ready     (tx_ready),
    .rx_ready     (rx_ready),
    .err_in       ({framing_err, parity_err, overrun_err}),
    .lsr_rd       (lsr_rd),
    .iir_rd       (iir_rd),
    .thr_wr       (thr_wr),
    .ier_thre_set (ier_thre_set),
    .sticky       (sticky),
    .iir          (iir),
    .intr         (intr)
  );

  assign bus.rdata     = rdata_reg;
  assign data_bits     = lcr_data_bits(lcr_reg[LCR_WLS1:LCR_WLS0]);
  assign stop_bits     = lcr_reg[LCR_STB] ? 2'd2 : 2'd1;
  assign parity_en     = lcr_reg[LCR_PEN];
  assign parity_even   = lcr_reg[LCR_EPS];
  assign divisor_latch = dl_reg;
  assign psd           = psd_reg;
  assign new_baud      = new_baud_reg;

endmodule

// File: doc/uart_regs.md
# uart_regs

16550-compatible host register file sitting directly upstream of `uart_top`. Decodes an 8-bit, 3-bit-address host bus into THR/RBR/IER/IIR/FCR/LCR/MCR/LSR/MSR/SCR/DLL/DLM/PSD. Drives the `uart_top` TX-write, RX-read and configuration ports, folds its status and error flags into LSR, and produces a prioritised interrupt.

## Interface

Parameters:
- `DL_WIDTH`, default 16: divisor latch width. DLL holds bits [7:0]; DLM holds bits [DL_WIDTH-1:8].
- `PSD_WIDTH`, default 4: prescaler width.
- `DEFAULT_DL`, default 651: divisor value after reset.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cs`, `we`, `re`  in  1 each  host chip select, write strobe, read strobe. `we` and `re` are never both high.
- `addr`  in  3  register address.
- `wdata`  in  8  host write data.
- `rdata`  out  8  registered host read data.
- `intr`  out  1  interrupt request, active high.
- `wr_en`  out  1  pulse to `uart_top`: push `wr_data` into TX.
- `wr_data`  out  8  equals `wdata`.
- `tx_ready`  in  1  `uart_top` TX can accept a byte.
- `rd_en`  out  1  pulse to `uart_top`: pop RX byte.
- `rd_data`  in  8  `uart_top` RX head byte, valid while `rx_ready` is high.
- `rx_ready`  in  1  RX byte available.
- `parity_err`, `framing_err`, `overrun_err`  in  1 each  `uart_top` error flags, sampled every cycle.
- `stop_bits`  out  2, `parity_en`  out  1, `parity_even`  out  1, `data_bits`  out  4: line configuration.
- `divisor_latch`  out  `DL_WIDTH`, `psd`  out  `PSD_WIDTH`: baud configuration.
- `new_baud`  out  1  one-cycle pulse telling `uart_top` to reload its baud settings.

## Operation

DLAB is LCR[7].

Address map (`wr` = `cs&we`, `rd` = `cs&re`):
- **0:**
  - DLAB=0 write → THR.
  - DLAB=0 read → RBR.
  - DLAB=1 → DLL.
- **1:**
  - DLAB=0 → IER. Bit0 = RDA, bit1 = THRE, bit2 = RLS. Bits [7:3] read 0.
  - DLAB=1 → DLM.
- **2:** read → IIR. Write → FCR, accepted and ignored.
- **3:** LCR.
  - [1:0] sets `data_bits` = 5 + value.
  - [2] sets `stop_bits`: 0 → 2'd1, 1 → 2'd2.
  - [3] drives `parity_en`; [4] drives `parity_even`.
  - [6:5] are stored with no effect.
- **4:** MCR, stored only.
- **5:**
  - DLAB=0 read → LSR; LSR writes are ignored.
  - DLAB=1 → PSD[`PSD_WIDTH`-1:0].
- **6:** MSR, reads 0.
- **7:** SCR scratch register.

THR write:
- `wr_en` = wr & addr==0 & !DLAB & `tx_ready`. This is combinational, with `wr_data` = `wdata`.
- A write while `tx_ready`=0 is dropped.

RBR read:
- `rd_en` = rd & addr==0 & !DLAB & `rx_ready`. This is combinational.
- `rdata` captures `rd_data` on the same edge.
- With `rx_ready`=0, `rdata` returns 0 and no pop occurs.

LSR bit map:
- bit0 = `rx_ready`.
- bit1 OE, bit2 PE, bit3 FE: sticky bits, set by the corresponding error input.
- bit4 = 0.
- bit5 = bit6 = `tx_ready`.
- bit7 = PE | FE.

LSR sticky-bit rules:
- An LSR read returns the current bits and clears the sticky bits at that edge.
- If an error input is high on the same edge as the clearing read, the bit stays set.

THRE pending flag:
- Set on a `tx_ready` 0→1 edge, or when IER[1] is written 0→1 while `tx_ready`=1.
- Cleared by a THR write, or by an IIR read that returns 0x02.
- The set condition wins over the clear condition.

IIR priority, highest first:
- RLS: IER[2] & (OE|PE|FE) → 0x06.
- RDA: IER[0] & `rx_ready` → 0x04.
- THRE: IER[1] & pending → 0x02.
- Otherwise 0x01.

`intr` = (IIR[0] == 0), registered.

`new_baud` pulses:
- In the first cycle after reset deassertion.
- In the cycle after any write to DLL, DLM or PSD. `divisor_latch`/`psd` already hold the new value in that cycle.
- Back-to-back writes give back-to-back pulses.

## Timing

- All registers update on the write edge. Configuration outputs reflect the new value from the next cycle.
- Read latency: `rdata` is valid one cycle after the `rd` strobe and holds until the next read.
- Reset values:
  - `rdata`=0, `intr`=0, IER=0, LCR=0x03, so `data_bits`=8, `stop_bits`=1, `parity_en`=0 and `parity_even`=0.
  - MCR=0, SCR=0.
  - `divisor_latch`=`DEFAULT_DL`, `psd`=0.
  - Sticky bits clear, THRE pending flag clear, `new_baud`=0 while reset is asserted.
- Reset asserted mid-transaction aborts it. No `wr_en`/`rd_en` pulse is produced while `rst_n`=0.

## Structure

- `uart_regs_pkg` holds:
  - address constants `ADDR_RBR_THR` … `ADDR_SCR`;
  - IIR codes `IIR_NONE`/`IIR_THRE`/`IIR_RDA`/`IIR_RLS`;
  - LCR and LSR bit-index constants.
- Sub-module `uart_int_ctrl` owns the THRE pending flag, the sticky LSR error bits, IIR prioritisation and `intr`.
- `uart_regs` owns decode, storage and `uart_top` handshakes.

## Test plan

- **Reset defaults:** release `rst_n` → `new_baud` pulses exactly once; `divisor_latch`=651, `data_bits`=8, `stop_bits`=1; LCR reads 0x03 and IIR reads 0x01.
- **Baud programming:** write LCR=0x83, DLL=0x8B, DLM=0x02, PSD(addr5)=0x3 → `divisor_latch`=0x028B and `psd`=3; three `new_baud` pulses, each one cycle after its write. Clearing LCR=0x03 restores THR/IER access.
- **TX path:** with `tx_ready`=1, write THR=0xA5 → `wr_en` high one cycle with `wr_data`=0xA5. With `tx_ready`=0, write THR=0x3C → no `wr_en`.
- **RX path:** IER=0x01, `rx_ready`=1, `rd_data`=0x3C → `intr`=1, IIR=0x04. RBR read → `rdata`=0x3C next cycle and `rd_en` one cycle. Dropping `rx_ready` clears `intr`.
- **Error priority:** IER=0x07, pulse `framing_err` while `rx_ready`=1 → IIR=0x06 and LSR=0x89. LSR read clears FE, after which IIR=0x04.
- **THRE:** IER=0x02, `tx_ready` 0→1 → IIR=0x02 and `intr`=1. IIR read clears it → next IIR read returns 0x01.
